// File: rtl/exception_encoder_if.sv
// exception_encoder_if
//   Groups the pipeline exception requests and the coprocessor 0 side
//   outputs of exception_encoder into one bundle.
//
//   Requests (pipeline -> encoder):
//     id_valid, id_ri, id_syscall, id_pc[31:0]   ID stage request
//     ex_valid, ex_ovf, ex_pc[31:0]              EX stage request
//   Results (encoder -> coprocessor 0 / pipeline):
//     exception_bus[66:0]  {ovf, ri, sys, epc[31:0], bad_addr[31:0]}
//     flush                squash IF/ID/EX
//     busy                 encoder FSM not idle
//     exc_count[7:0]       exceptions raised, modulo 256
//     fsm_state[1:0]       debug view of the encoder FSM state
//
//   Handshake: requests are level signals with no ready. The encoder
//   samples them only on an edge where it can accept (IDLE, or the last
//   FLUSH cycle); a request not present on such an edge is simply lost.
//   exception_bus is nonzero for exactly the one cycle of the raise.
//
//   Modports: master = request producer / bus consumer, slave = encoder.
interface exception_encoder_if;
  logic        id_valid;
  logic        id_ri;
  logic        id_syscall;
  logic [31:0] id_pc;
  logic        ex_valid;
  logic        ex_ovf;
  logic [31:0] ex_pc;
  logic [66:0] exception_bus;
  logic        flush;
  logic        busy;
  logic [7:0]  exc_count;
  logic [1:0]  fsm_state;

  modport master (
    output id_valid, id_ri, id_syscall, id_pc,
    output ex_valid, ex_ovf, ex_pc,
    input  exception_bus, flush, busy, exc_count, fsm_state
  );

  modport slave (
    input  id_valid, id_ri, id_syscall, id_pc,
    input  ex_valid, ex_ovf, ex_pc,
    output exception_bus, flush, busy, exc_count, fsm_state
  );
endinterface

// File: rtl/exception_encoder.sv
// exception_encoder
//   Picks the oldest pending exception request (EX overflow over ID
//   reserved-instruction over ID syscall), drives the registered 67-bit
//   exception_bus for one cycle and then holds flush for FLUSH_CYCLES more
//   cycles while the pipeline drains.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset; release is synchronized by a
//            2-flop chain before the FSM may leave IDLE
//     bus    exception_encoder_if.slave (requests in, bus/flush/busy/
//            exc_count/fsm_state out)
//
//   Parameter:
//     FLUSH_CYCLES  cycles flush stays high after the raise cycle (1..15)
//
//   Optional feature macro: EXC_BADADDR_EN
//     defined   : exception_bus[31:0] repeats the faulting PC during RAISE
//     undefined : exception_bus[31:0] is always 0
module exception_encoder #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input logic                 clk,
  input logic                 reset,
  exception_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic [1:0]  rst_sync;
  logic [66:0] exc_bus_q;
  logic        flush_q;
  logic        busy_q;
  logic [7:0]  count_q;

  logic        req_ovf;
  logic        req_ri;
  logic        req_sys;
  logic        req_any;
  logic        ready;
  logic [2:0]  win_cause;
  logic [31:0] win_epc;
  logic [31:0] win_badaddr;
  logic [66:0] win_word;

  // Reset release synchronizer: the FSM may accept a request only once
  // the release has passed both flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign ready = rst_sync[1];

  // Qualified requests. A syscall alongside RI in the same instruction is
  // dropped; EX overflow belongs to the older instruction and wins.
  always_comb begin
    req_ovf     = bus.ex_valid & bus.ex_ovf;
    req_ri      = bus.id_valid & bus.id_ri;
    req_sys     = bus.id_valid & bus.id_syscall & ~bus.id_ri;
    req_any     = req_ovf | req_ri | req_sys;
    win_cause   = 3'b000;
    win_epc     = 32'h0;
    if (req_ovf) begin
      win_cause = 3'b100;
      win_epc   = bus.ex_pc;
    end else if (req_ri) begin
      win_cause = 3'b010;
      win_epc   = bus.id_pc;
    end else if (req_sys) begin
      win_cause = 3'b001;
      win_epc   = bus.id_pc;
    end
`ifdef EXC_BADADDR_EN
    win_badaddr = win_epc;
`else
    win_badaddr = 32'h0;
`endif
    win_word    = {win_cause, win_epc, win_badaddr};
  end

  // Single FSM. The last FLUSH cycle (drain_cnt == 0) is the cycle in which
  // the state returns to IDLE, so a request present then is accepted
  // directly; this gives the FLUSH_CYCLES+1 minimum raise spacing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= 4'd0;
      exc_bus_q <= 67'd0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ready && req_any) begin
            state     <= RAISE;
            exc_bus_q <= win_word;
            flush_q   <= 1'b1;
            busy_q    <= 1'b1;
            count_q   <= count_q + 8'd1;
          end
        end
        RAISE: begin
          state     <= FLUSH;
          exc_bus_q <= 67'd0;
          drain_cnt <= DRAIN_LOAD;
        end
        FLUSH: begin
          if (drain_cnt != 4'd0) begin
            drain_cnt <= drain_cnt - 4'd1;
          end else if (req_any) begin
            state     <= RAISE;
            exc_bus_q <= win_word;
            count_q   <= count_q + 8'd1;
          end else begin
            state   <= IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          drain_cnt <= 4'd0;
          exc_bus_q <= 67'd0;
          flush_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.exception_bus = exc_bus_q;
  assign bus.flush         = flush_q;
  assign bus.busy          = busy_q;
  assign bus.exc_count     = count_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_exception_encoder.sv
// tb_exception_encoder
//   Self-checking bench for exception_encoder (FLUSH_CYCLES = 3).
//   Drivers push the expected exception_bus word for every request that
//   should raise; a negedge monitor pops and compares whenever the bus is
//   nonzero and flags any bus activity nobody expected.
module tb_exception_encoder;

  localparam int W = 67;

  logic clk;
  logic reset;

  exception_encoder_if bus_if ();

  exception_encoder #(.FLUSH_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] make_bus(input logic [2:0] cause,
                                            input logic [31:0] epc);
`ifdef EXC_BADADDR_EN
    return {cause, epc, epc};
`else
    return {cause, epc, 32'h0};
`endif
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && bus_if.exception_bus !== '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_raise", bus_if.exception_bus, '0);
      end else begin
        check_eq("bus", bus_if.exception_bus, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    bus_if.id_valid   = 1'b0;
    bus_if.id_ri      = 1'b0;
    bus_if.id_syscall = 1'b0;
    bus_if.id_pc      = 32'h0;
    bus_if.ex_valid   = 1'b0;
    bus_if.ex_ovf     = 1'b0;
    bus_if.ex_pc      = 32'h0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Expected word for one request pattern, by cause priority.
  task automatic push_expect(input logic exv, input logic ovf, input logic idv,
                             input logic ri, input logic sys,
                             input logic [31:0] expc, input logic [31:0] idpc);
    if (exv && ovf)       exp_q.push_back(make_bus(3'b100, expc));
    else if (idv && ri)   exp_q.push_back(make_bus(3'b010, idpc));
    else if (idv && sys)  exp_q.push_back(make_bus(3'b001, idpc));
  endtask

  // Called at a negedge; presents the request for one edge and returns at
  // the following negedge with the inputs cleared.
  task automatic drive_req(input logic exv, input logic ovf, input logic idv,
                           input logic ri, input logic sys,
                           input logic [31:0] expc, input logic [31:0] idpc);
    bus_if.ex_valid   = exv;
    bus_if.ex_ovf     = ovf;
    bus_if.ex_pc      = expc;
    bus_if.id_valid   = idv;
    bus_if.id_ri      = ri;
    bus_if.id_syscall = sys;
    bus_if.id_pc      = idpc;
    push_expect(exv, ovf, idv, ri, sys, expc, idpc);
    @(negedge clk);
    clear_inputs();
  endtask

  // ---------------- tests ----------------
  initial begin
    int run;
    int seen;
    logic [31:0] pc;
    int sel;

    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    check_eq("reset_bus",   bus_if.exception_bus, '0);
    check_eq("reset_flush", W'(bus_if.flush), W'(0));
    check_eq("reset_busy",  W'(bus_if.busy), W'(0));
    check_eq("reset_count", W'(bus_if.exc_count), W'(0));
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single EX overflow: one-cycle latency, flush for 1+3 cycles.
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 32'h0);
    check_eq("ovf_flush", W'(bus_if.flush), W'(1));
    check_eq("ovf_busy",  W'(bus_if.busy), W'(1));
    check_eq("ovf_count", W'(bus_if.exc_count), W'(1));
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus_if.flush) run++;
      @(negedge clk);
    end
    check_eq("flush_len", W'(run), W'(4));
    check_eq("idle_busy", W'(bus_if.busy), W'(0));

    // EX overflow and ID syscall on the same edge: overflow only.
    drive_req(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0020, 32'h0040_0024);
    repeat (6) @(negedge clk);

    // RI and syscall together: RI only.
    drive_req(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0040_0100);
    repeat (6) @(negedge clk);

    // Syscall held through FLUSH: raised once more as the FSM leaves FLUSH.
    reset_dut();
    bus_if.id_valid   = 1'b1;
    bus_if.id_syscall = 1'b1;
    bus_if.id_pc      = 32'h0040_0200;
    exp_q.push_back(make_bus(3'b001, 32'h0040_0200));
    @(negedge clk);
    bus_if.id_pc = 32'h0040_0204;
    exp_q.push_back(make_bus(3'b001, 32'h0040_0204));
    repeat (4) @(negedge clk);
    clear_inputs();
    check_eq("held_sys_count", W'(bus_if.exc_count), W'(2));
    repeat (8) @(negedge clk);
    check_eq("held_sys_final", W'(bus_if.exc_count), W'(2));

    // Reset in the 2nd FLUSH cycle aborts at once.
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0300, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort_bus",   bus_if.exception_bus, '0);
    check_eq("abort_flush", W'(bus_if.flush), W'(0));
    check_eq("abort_busy",  W'(bus_if.busy), W'(0));
    check_eq("abort_count", W'(bus_if.exc_count), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("abort_after_busy",  W'(bus_if.busy), W'(0));
    check_eq("abort_after_flush", W'(bus_if.flush), W'(0));

    // Reset release: a request held from release is not taken on the
    // first edge, and is taken within a few edges.
    reset = 1'b0;
    @(negedge clk);
    bus_if.ex_valid = 1'b1;
    bus_if.ex_ovf   = 1'b1;
    bus_if.ex_pc    = 32'h0040_0400;
    reset = 1'b1;
    exp_q.push_back(make_bus(3'b100, 32'h0040_0400));
    @(negedge clk);
    check_eq("sync_edge1_busy", W'(bus_if.busy), W'(0));
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      @(negedge clk);
      if (bus_if.busy) seen = 1;
    end
    clear_inputs();
    check_eq("sync_accept", W'(seen), W'(1));
    repeat (6) @(negedge clk);

    // 256 back-to-back raises with random causes: counter wraps to 0.
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      pc  = $urandom_range(32'h0040_0000, 32'h004F_FFFC) & 32'hFFFF_FFFC;
      sel = $urandom_range(0, 2);
      case (sel)
        0: drive_req(1'b1, 1'b1, 1'b1, $urandom_range(0, 1) == 1, 1'b1, pc, pc + 32'd4);
        1: drive_req(1'b0, 1'b0, 1'b1, 1'b1, $urandom_range(0, 1) == 1, 32'h0, pc);
        default: drive_req(1'b0, $urandom_range(0, 1) == 1, 1'b1, 1'b0, 1'b1, pc + 32'd8, pc);
      endcase
      if (i == 254) check_eq("count_255", W'(bus_if.exc_count), W'(255));
      if (i == 255) check_eq("count_wrap", W'(bus_if.exc_count), W'(0));
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Unqualified requests never raise.
    bus_if.id_valid = 1'b0;
    bus_if.id_ri    = 1'b1;
    bus_if.id_pc    = 32'h0040_0500;
    bus_if.ex_valid = 1'b0;
    bus_if.ex_ovf   = 1'b1;
    bus_if.ex_pc    = 32'h0040_0504;
    run = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.busy) run++;
    end
    clear_inputs();
    check_eq("unqualified_busy",  W'(run), W'(0));
    check_eq("unqualified_count", W'(bus_if.exc_count), W'(0));

    repeat (4) @(negedge clk);
    check_eq("exp_q_empty", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
